vision_frame_ctrl: RTL

//  Frame sequencer and controller for the pixel-processing datapath (blur/HSV/edge).

---
 rtl/vision_pkg.sv | 22 ++
 rtl/vision_frame_ctrl_bbox_accum.sv | 86 ++++++++
 rtl/vision_frame_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vision_pkg.sv
// Shared types and default geometry for the vision frame controller.
package vision_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        BLUR = 2'd1,
        RED  = 2'd2,
        EDGE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DRAIN   = 2'd2,
        PUBLISH = 2'd3
    } fsm_t;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int CNT_W     = 20;

endpackage

// File: rtl/vision_frame_ctrl_bbox_accum.sv
// Per-frame detection accumulator: saturating hit count plus min/max extents,
// with a publish stage that holds the last completed frame's result.
module bbox_accum
    import vision_pkg::*;
#(
    parameter int XW         = 11,
    parameter int YW         = 11,
    parameter int MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             hit,
    input  logic [XW-1:0]    hit_x,
    input  logic [YW-1:0]    hit_y,
    input  logic             publish,
    output logic             bbox_valid,
    output logic [XW-1:0]    bbox_left,
    output logic [XW-1:0]    bbox_right,
    output logic [YW-1:0]    bbox_top,
    output logic [YW-1:0]    bbox_bottom,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

    logic [CNT_W-1:0] cnt;
    logic [XW-1:0]    min_x;
    logic [XW-1:0]    max_x;
    logic [YW-1:0]    min_y;
    logic [YW-1:0]    max_y;

    // Running count and extents; clear wins over a same-cycle hit because that hit belongs to the old frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
        end else if (clear) begin
            cnt   <= '0;
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
        end else if (hit) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (hit_x <= min_x) begin
                min_x <= hit_x;
            end
            if (hit_x >= max_x) begin
                max_x <= hit_x;
            end
            if (hit_y <= min_y) begin
                min_y <= hit_y;
            end
            if (hit_y >= max_y) begin
                max_y <= hit_y;
            end
        end
    end

    // Copy the accumulators to the visible box outputs once per completed frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bbox_valid  <= 1'b0;
            bbox_left   <= '0;
            bbox_right  <= '0;
            bbox_top    <= '0;
            bbox_bottom <= '0;
            pix_count   <= '0;
        end else if (publish) begin
            bbox_valid  <= (cnt >= CNT_MIN);
            bbox_left   <= min_x;
            bbox_right  <= max_x;
            bbox_top    <= min_y;
            bbox_bottom <= max_y;
            pix_count   <= cnt;
        end
    end

endmodule

// File: rtl/vision_frame_ctrl.sv
// Frame sequencer: tracks frames from sop/in_valid, generates pixel coordinates,
// aligns them with the delayed red_sector flag and publishes a per-frame bounding box.
// The display mode only changes at frame boundaries.
module vision_frame_ctrl
    import vision_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int XW         = 11,
    parameter int YW         = 11,
    parameter int DET_LAT    = 4,
    parameter int MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sop,
    input  logic             packet_video,
    input  logic             in_valid,
    input  logic             red_sector,
    input  logic [1:0]       mode_req,
    input  logic             mode_req_vld,
    output logic [1:0]       mode,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             bbox_valid,
    output logic [XW-1:0]    bbox_left,
    output logic [XW-1:0]    bbox_right,
    output logic [YW-1:0]    bbox_top,
    output logic [YW-1:0]    bbox_bottom,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
    localparam logic [3:0]    DRAIN_LAST = 4'(DET_LAT - 1);

    logic [1:0]    rst_sync;
    logic          rst_int_n;
    fsm_t          state;
    fsm_t          state_next;
    logic          beat;
    logic          start_frame;
    logic          abort_frame;
    logic          adv;
    logic          publish;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [3:0]    drain_cnt;
    logic          beat_vld;
    logic [XW-1:0] beat_x;
    logic [YW-1:0] beat_y;
    logic          pipe_vld [DET_LAT];
    logic [XW-1:0] pipe_x   [DET_LAT];
    logic [YW-1:0] pipe_y   [DET_LAT];
    logic          hit;
    mode_t         shadow;
    mode_t         mode_q;

    // Reset synchroniser: assertion reaches every flop at once, release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];
    assign beat      = in_valid & packet_video;

    // State register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle frame control strobes.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        abort_frame = 1'b0;
        adv         = 1'b0;
        publish     = 1'b0;
        case (state)
            IDLE: begin
                if (beat && sop) begin
                    start_frame = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat && sop) begin
                    abort_frame = 1'b1;
                end else if (beat) begin
                    adv = 1'b1;
                    if ((x_cnt == X_LAST) && (y_cnt == Y_LAST)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                publish    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Count the cycles spent waiting for the last detections to arrive.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 4'd1;
        end
    end

    // x_cnt/y_cnt point at the next expected beat; x/y report the beat just accepted.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            x     <= '0;
            y     <= '0;
        end else if (start_frame || abort_frame) begin
            x     <= '0;
            y     <= '0;
            x_cnt <= XW'(1);
            y_cnt <= '0;
        end else if (adv) begin
            x <= x_cnt;
            y <= y_cnt;
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    assign beat_vld = start_frame | abort_frame | adv;
    assign beat_x   = (start_frame || abort_frame) ? '0 : x_cnt;
    assign beat_y   = (start_frame || abort_frame) ? '0 : y_cnt;

    // Coordinate delay line matching the detector latency; an abort drops the old frame's beats in flight.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < DET_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_x[i]   <= '0;
                pipe_y[i]   <= '0;
            end
        end else begin
            pipe_vld[0] <= beat_vld;
            pipe_x[0]   <= beat_x;
            pipe_y[0]   <= beat_y;
            for (int i = 1; i < DET_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] & ~abort_frame;
                pipe_x[i]   <= pipe_x[i-1];
                pipe_y[i]   <= pipe_y[i-1];
            end
        end
    end

    assign hit = pipe_vld[DET_LAT-1] & red_sector;

    bbox_accum #(
        .XW         (XW),
        .YW         (YW),
        .MIN_PIXELS (MIN_PIXELS)
    ) u_accum (
        .clk         (clk),
        .reset_n     (rst_int_n),
        .clear       (start_frame | abort_frame),
        .hit         (hit),
        .hit_x       (pipe_x[DET_LAT-1]),
        .hit_y       (pipe_y[DET_LAT-1]),
        .publish     (publish),
        .bbox_valid  (bbox_valid),
        .bbox_left   (bbox_left),
        .bbox_right  (bbox_right),
        .bbox_top    (bbox_top),
        .bbox_bottom (bbox_bottom),
        .pix_count   (pix_count)
    );

    // Shadow mode register: any strobe overwrites it, last write wins.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            shadow <= PASS;
        end else if (mode_req_vld) begin
            shadow <= mode_t'(mode_req);
        end
    end

    // Active mode moves only at publish; a strobe in that same cycle is taken directly.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            mode_q <= PASS;
        end else if (publish) begin
            mode_q <= mode_req_vld ? mode_t'(mode_req) : shadow;
        end
    end

    assign mode = mode_q;

    // One-cycle status pulses.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= publish;
            frame_abort <= abort_frame;
        end
    end

endmodule
